// File: rtl/vector_vtop.sv
// rtl/vector_vtop.sv - registered parity, popcount and reversed-index copy of an 8-bit operand
module vector_vtop (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    output logic       res1,
    output logic [3:0] res2,
    output logic [0:7] res3
);

    logic       res1_q, res1_d;
    logic [3:0] res2_q, res2_d;
    logic [0:7] res3_q, res3_d;

    // Next-state: odd parity, full-width ones count, and MSB-first copy onto the ascending bus
    always_comb begin
        res1_d = ^data;
        res2_d = 4'd0;
        res3_d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            res2_d    = res2_d + {3'b000, data[i]};
            res3_d[i] = data[7-i];
        end
    end

    // Output registers; reset clears them at once and drops any sample in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res1_q <= 1'b0;
            res2_q <= 4'd0;
            res3_q <= 8'd0;
        end else begin
            res1_q <= res1_d;
            res2_q <= res2_d;
            res3_q <= res3_d;
        end
    end

    assign res1 = res1_q;
    assign res2 = res2_q;
    assign res3 = res3_q;

endmodule

// File: tb/tb_vector_vtop.sv
// tb/tb_vector_vtop.sv - self-checking bench for vector_vtop
module tb_vector_vtop;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       res1;
    logic [3:0] res2;
    logic [0:7] res3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic [3:0] c;
        logic [7:0] r3;
    } vec_t;

    vec_t tbl [7];

    vector_vtop dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .res1 (res1),
        .res2 (res2),
        .res3 (res3)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic int ref_popcount(input int v);
        int n = 0;
        int x = v;
        while (x != 0) begin
            x = x & (x - 1);
            n++;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " res1"}, {31'd0, res1}, 32'd0);
        check({tag, " res2"}, {28'd0, res2}, 32'd0);
        check({tag, " res3"}, {24'd0, res3}, 32'd0);
    endtask

    task automatic check_model(input string tag, input int d);
        int c;
        c = ref_popcount(d);
        check({tag, " res2"}, {28'd0, res2}, c);
        check({tag, " res1"}, {31'd0, res1}, c % 2);
        check({tag, " res3"}, {24'd0, res3}, d);
    endtask

    initial begin
        tbl[0] = '{8'hF3, 1'b0, 4'd6, 8'hF3};
        tbl[1] = '{8'hAA, 1'b0, 4'd4, 8'hAA};
        tbl[2] = '{8'h55, 1'b0, 4'd4, 8'h55};
        tbl[3] = '{8'h6D, 1'b1, 4'd5, 8'h6D};
        tbl[4] = '{8'hFC, 1'b0, 4'd6, 8'hFC};
        tbl[5] = '{8'h00, 1'b0, 4'd0, 8'h00};
        tbl[6] = '{8'hFF, 1'b0, 4'd8, 8'hFF};

        rst  = 1'b0;
        data = 8'h00;

        // asynchronous reset before any clock edge
        #2 rst = 1'b1;
        #3 check_zero("reset_async");
        data = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_zero($sformatf("reset_hold%0d", k));
        end
        rst  = 1'b0;
        data = 8'h6D;
        #1 check_zero("reset_release_pre_edge");
        @(negedge clk);
        check_model("first_after_reset", 8'h6D);

        // table vectors, each held 200 ns
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            data = tbl[v].d;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                check($sformatf("tbl%0d_c%0d res1", v, k), {31'd0, res1}, {31'd0, tbl[v].p});
                check($sformatf("tbl%0d_c%0d res2", v, k), {28'd0, res2}, {28'd0, tbl[v].c});
                check($sformatf("tbl%0d_c%0d res3", v, k), {24'd0, res3}, {24'd0, tbl[v].r3});
            end
        end
        check("tbl_f3_res3_0", {31'd0, res3[0]}, 32'd1);

        // extremes one clock each
        data = 8'h00;
        @(negedge clk);
        check_model("ext_00", 8'h00);
        data = 8'hFF;
        @(negedge clk);
        check_model("ext_ff", 8'hFF);

        // latency: AA held, then 6D applied one cycle before an edge
        data = 8'hAA;
        @(negedge clk);
        @(negedge clk);
        check_model("lat_aa", 8'hAA);
        data = 8'h6D;
        #1 check_model("lat_aa_no_comb_path", 8'hAA);
        @(posedge clk);
        #1 check_model("lat_6d", 8'h6D);

        // async reset mid-period with 6D steady
        repeat (3) @(negedge clk);
        @(posedge clk);
        #5 rst = 1'b1;
        #1 check_zero("mid_rst_immediate");
        @(negedge clk);
        check_zero("mid_rst_negedge");
        @(posedge clk);
        #1 check_zero("mid_rst_across_edge");
        @(negedge clk);
        rst = 1'b0;
        #1 check_zero("mid_rst_released_pre_edge");
        @(posedge clk);
        #1 check_model("mid_rst_restore", 8'h6D);

        // in-flight sample discarded and not replayed
        data = 8'hAA;
        @(posedge clk);
        #1 data = 8'h55;
        #3 rst = 1'b1;
        @(negedge clk);
        data = 8'h0F;
        @(negedge clk);
        rst = 1'b0;
        #1 check_zero("discard_pre_edge");
        @(posedge clk);
        #1 check_model("discard_new", 8'h0F);

        // randomized stream against the reference model
        begin
            int prev;
            @(negedge clk);
            prev = $urandom_range(0, 255);
            data = prev[7:0];
            for (int n = 0; n < 400; n++) begin
                int nxt;
                @(negedge clk);
                check_model($sformatf("rand%0d", n), prev);
                nxt  = $urandom_range(0, 255);
                data = nxt[7:0];
                prev = nxt;
            end
        end

        // exhaustive sweep with per-bit reversal and parity invariant
        for (int v = 0; v < 256; v++) begin
            @(negedge clk);
            data = v[7:0];
            @(negedge clk);
            check_model($sformatf("sweep%0d", v), v);
            check($sformatf("sweep%0d res1_vs_res2lsb", v), {31'd0, res1}, {31'd0, res2[0]});
            for (int b = 0; b < 8; b++)
                check($sformatf("sweep%0d res3[%0d]", v, b), {31'd0, res3[b]}, (v >> (7 - b)) & 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_vtop.md
VECTOR_VTOP -- requirements
Module: vector_vtop

Interface
REQ-001: clk  input  1  single system clock; all state updates on its rising edge.
REQ-002: rst  input  1  reset, asynchronous, active-high; one clock, no other clock domains.
REQ-003: data  input  [7:0]  8-bit operand vector, sampled every rising clk edge while rst is low.
REQ-004: res1  output  1  registered odd-parity flag of data.
REQ-005: res2  output  [3:0]  registered population count (number of 1 bits) of data, range 0..8.
REQ-006: res3  output  [0:7]  registered copy of data on an ascending-index bus.
- res3[0] is the MSB.
- res3[i] = data[7-i].
- Numeric value of res3 equals numeric value of data.

Function
REQ-007: The block SHALL register all three outputs; there SHALL be no combinational path from data to any output.
REQ-008: Latency SHALL be exactly one clock.
- Outputs after rising edge N reflect data sampled at edge N.
- No handshake; a new sample is taken every cycle.
REQ-009: res1 SHALL equal the XOR-reduction of data[7:0].
- 1 when the count of ones is odd, 0 when even.
REQ-010: res2 SHALL equal the unsigned count of set bits in data[7:0].
- Computed at full 4-bit width with no truncation.
- data=8'h00 gives 0; data=8'hFF gives 8 (4'b1000).
REQ-011: res3 SHALL be the bit-for-bit mapping res3[i] = data[7-i] for i = 0..7.
REQ-012: res1 SHALL equal res2[0] on every cycle; any mismatch is a design error.
REQ-013: When data is held constant over consecutive cycles, the outputs SHALL hold constant values.
REQ-014: Boundary cases at the data extremes:
- data=8'h00 gives res1=0, res2=0, res3=8'h00.
- data=8'hFF gives res1=0, res2=8, res3=8'hFF.
REQ-015: An X or Z on a data bit SHALL NOT be masked; propagation of X/Z on inputs is undefined and is excluded from verification.

Reset
REQ-016: While rst is high, res1, res2 and res3 SHALL be 0.
- Assertion clears the outputs immediately, independent of clk.
- The outputs remain 0 for as long as rst stays high.
REQ-017: After rst is deasserted, the first rising clk edge SHALL load outputs computed from the current data.
REQ-018: Reset asserted mid-stream SHALL discard the in-flight sample.
- After deassertion, outputs return only on the next clock edge.
- The discarded sample is not replayed.

Verification
REQ-019: Sequence checks, each value held 200 ns with one clock latency to the outputs:
- data=8'hF3 -> res1=0, res2=6, res3=8'hF3 (res3[0]=1, res3[4]=0, res3[5]=0).
- data=8'hAA -> res1=0, res2=4, res3=8'hAA (res3[0]=1, res3[1]=0).
- data=8'h55 -> res1=0, res2=4, res3=8'h55 (res3[0]=0, res3[7]=1).
- data=8'h6D -> res1=1, res2=5, res3=8'h6D.
- data=8'hFC -> res1=0, res2=6, res3=8'hFC.
REQ-020: Extremes: data=8'h00 then 8'hFF, one clock each -> res2 = 0 then 8; res1 = 0 in both cycles.
REQ-021: Async reset: with data=8'h6D in steady state, raise rst mid-clock-period.
- All outputs go to 0 before the next clk edge.
- After rst is lowered, the next edge restores res1=1, res2=5, res3=8'h6D.
REQ-022: Latency: change data from 8'hAA to 8'h6D one cycle before an edge.
- Outputs show the AA results until that edge.
- Outputs show the 6D results from that edge onward.
REQ-023: Exhaustive sweep of data 0..255:
- res2 equals the reference popcount.
- res1 equals res2[0].
- res3 equals data, with per-bit index reversal checked.
